// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: queues read/write commands and runs each as an APB4 transfer,
// with a PREADY watchdog and one in-order response per command.
module apb_master_ctrl #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int STRB_W        = DATA_W / 8,
    localparam int LVL_W         = $clog2(CMD_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_strb,
    input  logic [2:0]        cmd_prot,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    output logic [2:0]        pprot,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy,
    output logic [LVL_W-1:0]  cmd_level
);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int TO_W  = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t r_state, w_next;

    logic [ADDR_W-1:0] r_q_addr  [CMD_DEPTH];
    logic [DATA_W-1:0] r_q_wdata [CMD_DEPTH];
    logic [STRB_W-1:0] r_q_strb  [CMD_DEPTH];
    logic [2:0]        r_q_prot  [CMD_DEPTH];
    logic              r_q_write [CMD_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [TO_W-1:0]   r_tcnt;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata, r_rsp_rdata;
    logic [STRB_W-1:0] r_pstrb;
    logic [2:0]        r_pprot;
    logic              r_psel, r_penable, r_pwrite;
    logic              r_rsp_valid, r_rsp_err, r_rsp_timeout;
    logic              w_push, w_pop, w_done, w_abort;

    assign cmd_ready = r_level != LVL_W'(CMD_DEPTH);
    assign busy      = r_state != IDLE || r_level != '0;
    assign w_push    = cmd_valid && cmd_ready;
    // a new transfer may start only once any pending response is consumed
    assign w_pop     = r_state == IDLE && r_level != '0 && (!r_rsp_valid || rsp_ready);
    assign w_done    = r_state == ACCESS && pready;
    assign w_abort   = r_state == ACCESS && !pready && TIMEOUT_CYCLES != 0 && r_tcnt == TO_LIM;

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = w_pop ? SETUP : IDLE;
        else if (r_state == SETUP)
            w_next = ACCESS;
        else
            w_next = (w_done || w_abort) ? IDLE : ACCESS;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr]  <= cmd_addr;
            r_q_wdata[r_wr_ptr] <= cmd_wdata;
            r_q_strb[r_wr_ptr]  <= cmd_strb;
            r_q_prot[r_wr_ptr]  <= cmd_prot;
            r_q_write[r_wr_ptr] <= cmd_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_tcnt        <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_pprot       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_psel    <= w_next != IDLE;
            r_penable <= w_next == ACCESS;
            r_level   <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_tcnt   <= '0;
                r_paddr  <= r_q_addr[r_rd_ptr];
                r_pwrite <= r_q_write[r_rd_ptr];
                r_pwdata <= r_q_wdata[r_rd_ptr];
                r_pstrb  <= r_q_write[r_rd_ptr] ? r_q_strb[r_rd_ptr] : '0;
                r_pprot  <= r_q_prot[r_rd_ptr];
            end else if (r_state == ACCESS && !pready)
                r_tcnt <= r_tcnt + 1'b1;
            if (w_done || w_abort) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_rdata   <= (w_done && !r_pwrite) ? prdata : '0;
                r_rsp_err     <= w_abort || pslverr;
                r_rsp_timeout <= w_abort;
            end else if (rsp_ready)
                r_rsp_valid <= 1'b0;
        end
    end

    assign cmd_level   = r_level;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign paddr       = r_paddr;
    assign pwrite      = r_pwrite;
    assign pwdata      = r_pwdata;
    assign pstrb       = r_pstrb;
    assign pprot       = r_pprot;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed vector table plus FIFO-backpressure and
// mid-transfer reset sequences for apb_master_ctrl.
module tb_apb_master_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [11:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata, prdata_v;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr, busy, pmode;
    logic [2:0]  cmd_level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // in pmode the slave returns an address-tagged word so response order is visible
    assign prdata = pmode ? {20'hABCDE, paddr} : prdata_v;

    apb_master_ctrl #(.ADDR_W(12), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .busy(busy), .cmd_level(cmd_level)
    );

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          nwait;
        logic        slverr;
        logic [31:0] rdata;
        logic [3:0]  e_strb;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_to;
        int          e_acc;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_strb = v.strb; cmd_prot = v.prot;
        prdata_v = v.rdata; pslverr = v.slverr; pready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("lvl_after_push", cmd_level, 1);
        @(negedge clk);
        chk("setup_sel_en", {psel, penable}, 2'b10);
        chk("setup_paddr", paddr, v.addr);
        chk("setup_pwrite", pwrite, v.wr);
        chk("setup_pwdata", pwdata, v.wdata);
        chk("setup_pstrb", pstrb, v.e_strb);
        chk("setup_pprot", pprot, v.prot);
        chk("setup_busy", busy, 1);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (rsp_valid) break;
            n++;
            chk("access_sel_en", {psel, penable}, 2'b11);
            chk("access_paddr", paddr, v.addr);
            pready = n > v.nwait;
        end
        pready = 1'b0;
        pslverr = 1'b0;
        chk("rsp_valid", rsp_valid, 1);
        chk("access_cycles", n, v.e_acc);
        chk("rsp_rdata", rsp_rdata, v.e_rdata);
        chk("rsp_err", rsp_err, v.e_err);
        chk("rsp_timeout", rsp_timeout, v.e_to);
        chk("idle_psel", psel, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_consumed", rsp_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n, k, got;
        logic p;
        vt[0] = '{1'b1, 12'h004, 32'hA5A5_0001, 4'hF, 3'd0, 0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 1};
        vt[1] = '{1'b0, 12'h010, 32'h0, 4'hF, 3'd1, 3, 1'b0, 32'hDEAD_BEEF, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 4};
        vt[2] = '{1'b1, 12'h020, 32'h1234_5678, 4'h5, 3'd3, 1, 1'b1, 32'hFFFF_FFFF, 4'h5, 32'h0, 1'b1, 1'b0, 2};
        vt[3] = '{1'b0, 12'h030, 32'h0, 4'h3, 3'd2, 99, 1'b0, 32'h1111_1111, 4'h0, 32'h0, 1'b1, 1'b1, 8};
        vt[4] = '{1'b0, 12'h040, 32'h0, 4'h0, 3'd7, 0, 1'b0, 32'hCAFE_F00D, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 1};
        vt[5] = '{1'b0, 12'hFFC, 32'h0, 4'hF, 3'd4, 0, 1'b1, 32'h55AA_55AA, 4'h0, 32'h55AA_55AA, 1'b1, 1'b0, 1};
        vt[6] = '{1'b0, 12'h050, 32'h0, 4'h0, 3'd0, 7, 1'b0, 32'h0BAD_F00D, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b0, 8};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0; prdata_v = '0; pready = 1'b0;
        pslverr = 1'b0; pmode = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_psel_en", {psel, penable}, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_level", cmd_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_paddr", paddr, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", {psel, penable, rsp_valid, busy, cmd_ready}, 5'b00001);

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        pmode = 1'b1; pready = 1'b1; rsp_ready = 1'b0;
        cmd_write = 1'b0; cmd_strb = 4'hF; cmd_prot = 3'd0;
        k = 0; n = 0;
        while (k < 5 && n < 20) begin
            cmd_valid = 1'b1;
            cmd_addr = 12'h100 + 12'(4 * k);
            p = cmd_ready;
            @(negedge clk);
            if (p) k++;
            n++;
        end
        chk("fifo_pushes", k, 5);
        cmd_addr = 12'h114;
        chk("fifo_full_ready", cmd_ready, 0);
        chk("fifo_full_level", cmd_level, 4);
        repeat (3) @(negedge clk);
        chk("fifo_hold_level", cmd_level, 4);
        chk("fifo_hold_psel", psel, 0);
        chk("fifo_hold_busy", busy, 1);
        chk("fifo_hold_valid", rsp_valid, 1);
        chk("fifo_hold_rdata", rsp_rdata, 32'hABCD_E100);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        got = 0; n = 0;
        while (got < 5 && n < 60) begin
            if (rsp_valid) begin
                chk("fifo_order", rsp_rdata, 32'hABCD_E100 + 32'(4 * got));
                got++;
            end
            @(negedge clk);
            n++;
        end
        chk("fifo_rsp_count", got, 5);
        rsp_ready = 1'b0; pmode = 1'b0; pready = 1'b0;
        @(negedge clk);
        chk("fifo_drained", {busy, rsp_valid, cmd_level}, 5'b0);

        cmd_write = 1'b1; cmd_wdata = 32'h7777_0000;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            cmd_addr = 12'h200 + 12'(4 * i);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("mid_access", {psel, penable}, 2'b11);
        chk("mid_level", cmd_level, 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sel_en", {psel, penable}, 2'b00);
        chk("async_rst_level", cmd_level, 0);
        chk("async_rst_ready", cmd_ready, 1);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_quiet", {psel, rsp_valid, busy}, 3'b000);

        run_vec(vt[4]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
